// File: rtl/pe_dmem_ctrl.sv
// PE data memory controller: byte-lane PE load/store port with priority
// over a DMA word port that returns read data through a 2-entry FIFO.
module pe_dmem_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                    iClk,
  input  logic                    iReset,
  input  logic                    iAGU_DMEM_Write_Enable,
  input  logic                    iAGU_DMEM_Read_Enable,
  input  logic [DATA_WIDTH-1:0]   iAGU_DMEM_Address,
  input  logic [1:0]              iAGU_DMEM_Opcode,
  input  logic [DATA_WIDTH/8-1:0] iAGU_DMEM_Byte_Select,
  input  logic [DATA_WIDTH-1:0]   iAGU_DMEM_Store_Data,
  output logic [DATA_WIDTH-1:0]   oDMEM_EX_Data,
  input  logic                    iDMA_Req_Valid,
  output logic                    oDMA_Req_Ready,
  input  logic                    iDMA_Req_Write,
  input  logic [ADDR_WIDTH-1:0]   iDMA_Req_Addr,
  input  logic [DATA_WIDTH-1:0]   iDMA_Req_Wdata,
  output logic                    oDMA_Rsp_Valid,
  output logic [DATA_WIDTH-1:0]   oDMA_Rsp_Data,
  input  logic                    iDMA_Rsp_Ready,
  output logic                    oMisalign_Err
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] OP_W  = 2'b00;
  localparam logic [1:0] OP_H  = 2'b01;
  localparam logic [1:0] OP_SB = 2'b10;
  localparam logic [1:0] OP_UB = 2'b11;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  logic                  r_ld_vld;
  logic [1:0]            r_ld_off;
  logic [1:0]            r_ld_op;
  logic [DATA_WIDTH-1:0] r_ex_hold;
  logic                  r_merr;

  logic [DATA_WIDTH-1:0] r_fifo [2];
  logic                  r_wp;
  logic                  r_rp;
  logic [1:0]            r_cnt;
  logic                  r_rd_inflight;

  logic [ADDR_WIDTH-1:0] w_pe_idx;
  logic [ADDR_WIDTH-1:0] w_rd_idx;
  logic [1:0]            w_off;
  logic                  w_pe_any;
  logic                  w_mis;
  logic                  w_st_ok;
  logic                  w_ld_ok;
  logic [DATA_WIDTH-1:0] w_st_data;
  logic [15:0]           w_half;
  logic [7:0]            w_byte;
  logic [DATA_WIDTH-1:0] w_ld_ext;
  logic [1:0]            w_occ;
  logic                  w_dma_acc;
  logic                  w_dma_wr;
  logic                  w_dma_rd;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_fpop;
  logic                  w_unused_addr;

  assign w_pe_idx = iAGU_DMEM_Address[ADDR_WIDTH+1:2];
  assign w_off    = iAGU_DMEM_Address[1:0];
  assign w_pe_any = iAGU_DMEM_Write_Enable
                  | iAGU_DMEM_Read_Enable;

  assign w_unused_addr =
    ^{iAGU_DMEM_Address[DATA_WIDTH-1:ADDR_WIDTH+2]};

  always_comb begin
    w_mis = 1'b0;
    unique case (iAGU_DMEM_Opcode)
      OP_W:    w_mis = (w_off != 2'b00);
      OP_H:    w_mis = w_off[0];
      default: w_mis = 1'b0;
    endcase
  end

  // A write and a read in the same cycle resolve as a write only.
  assign w_st_ok = iAGU_DMEM_Write_Enable & ~w_mis & ~iReset;
  assign w_ld_ok = iAGU_DMEM_Read_Enable
                 & ~iAGU_DMEM_Write_Enable & ~w_mis;

  always_comb begin
    w_st_data = iAGU_DMEM_Store_Data;
    unique case (iAGU_DMEM_Opcode)
      OP_W: w_st_data = iAGU_DMEM_Store_Data;
      OP_H: begin
        for (int i = 0; i < DATA_WIDTH / 16; i++)
          w_st_data[16*i +: 16] = iAGU_DMEM_Store_Data[15:0];
      end
      default: begin
        for (int i = 0; i < NB; i++)
          w_st_data[8*i +: 8] = iAGU_DMEM_Store_Data[7:0];
      end
    endcase
  end

  assign w_occ = r_cnt + {1'b0, r_rd_inflight};

  assign oDMA_Req_Ready = ~w_pe_any & ~iReset
                        & (w_occ < 2'd2);

  assign w_dma_acc = iDMA_Req_Valid & oDMA_Req_Ready;
  assign w_dma_wr  = w_dma_acc & iDMA_Req_Write;
  assign w_dma_rd  = w_dma_acc & ~iDMA_Req_Write;

  // One shared read port: PE and DMA never use it in the same cycle.
  assign w_rd_idx = w_pe_any ? w_pe_idx : iDMA_Req_Addr;

  always_ff @(posedge iClk) begin
    r_rd_data <= r_mem[w_rd_idx];
    if (w_dma_wr)
      r_mem[iDMA_Req_Addr] <= iDMA_Req_Wdata;
    for (int b = 0; b < NB; b++) begin
      if (w_st_ok && iAGU_DMEM_Byte_Select[b])
        r_mem[w_pe_idx][8*b +: 8] <= w_st_data[8*b +: 8];
    end
  end

  assign w_half = r_rd_data[{r_ld_off[1], 4'b0000} +: 16];
  assign w_byte = r_rd_data[{r_ld_off, 3'b000} +: 8];

  always_comb begin
    w_ld_ext = r_rd_data;
    unique case (r_ld_op)
      OP_W:  w_ld_ext = r_rd_data;
      OP_H:  w_ld_ext = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
      OP_SB: w_ld_ext = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      OP_UB: w_ld_ext = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      default: w_ld_ext = r_rd_data;
    endcase
  end

  assign oDMEM_EX_Data = r_ld_vld ? w_ld_ext : r_ex_hold;
  assign oMisalign_Err = r_merr;

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_ld_vld  <= 1'b0;
      r_ld_off  <= 2'b00;
      r_ld_op   <= OP_W;
      r_ex_hold <= '0;
      r_merr    <= 1'b0;
    end else begin
      r_ld_vld <= w_ld_ok;
      if (w_ld_ok) begin
        r_ld_off <= w_off;
        r_ld_op  <= iAGU_DMEM_Opcode;
      end
      if (r_ld_vld)
        r_ex_hold <= w_ld_ext;
      if (w_pe_any && w_mis)
        r_merr <= 1'b1;
    end
  end

  // An in-flight read is visible at once; it bypasses an empty FIFO
  // when consumed in the same cycle.
  assign w_empty        = (r_cnt == 2'd0);
  assign oDMA_Rsp_Valid = ~w_empty | r_rd_inflight;
  assign oDMA_Rsp_Data  = w_empty ? r_rd_data : r_fifo[r_rp];

  assign w_pop  = oDMA_Rsp_Valid & iDMA_Rsp_Ready;
  assign w_fpop = w_pop & ~w_empty;
  assign w_push = r_rd_inflight & ~(w_pop & w_empty);

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      r_fifo[0]     <= '0;
      r_fifo[1]     <= '0;
      r_wp          <= 1'b0;
      r_rp          <= 1'b0;
      r_cnt         <= 2'd0;
      r_rd_inflight <= 1'b0;
    end else begin
      r_rd_inflight <= w_dma_rd;
      if (w_push) begin
        r_fifo[r_wp] <= r_rd_data;
        r_wp         <= ~r_wp;
      end
      if (w_fpop)
        r_rp <= ~r_rp;
      unique case ({w_push, w_fpop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule
